// File: rtl/iq_lockin_multi.sv
// rtl/iq_lockin_multi.sv - multi-channel IQ lock-in demodulator with block decimation
// Shared NCO mixes each channel to I/Q; products are summed over 2^DEC_LOG samples and scaled.
module iq_lockin_multi #(
   parameter int N        = 14,
   parameter int CH       = 2,
   parameter int PW       = 32,
   parameter int LA       = 10,
   parameter int DEC_LOG  = 4,
   parameter     LUT_FILE = "sin_lut.hex"
) (
   input  logic                                    CLK,
   input  logic                                    reset,
   input  logic [CH*N-1:0]                         sample_in,
   input  logic                                    sample_valid,
   input  logic [CH-1:0]                           otr_in,
   input  logic [PW-1:0]                           phase_inc,
   input  logic                                    phase_inc_load,
   input  logic [CH*PW-1:0]                        phase_ofs,
   input  logic [PW-1:0]                           ref_phase_inc,
   output logic                                    ref_out,
   output logic [CH*N-1:0]                         i_out,
   output logic [CH*N-1:0]                         q_out,
   output logic                                    out_valid,
   input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0]  sel_ch,
   input  logic                                    sel_q,
   output logic [N-1:0]                            mon_out,
   output logic [PW-1:0]                           inc_active,
   output logic [CH-1:0]                           ovf,
   input  logic                                    clear_ovf
);
   localparam int AW = 2*N + DEC_LOG;
   localparam int SH = N - 1 + DEC_LOG;
   localparam logic [LA-1:0] QTR = LA'(1 << (LA-2));
   localparam logic [DEC_LOG-1:0] LAST = '1;
   localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

   // Sine table is computed at elaboration so no external image has to travel with the RTL.
   function automatic logic signed [N-1:0] sin_entry(input int k);
      real v;
      v = $sin(6.283185307179586 * real'(k) / real'(1 << LA)) * real'((1 << (N-1)) - 1);
      return (v >= 0.0) ? N'($rtoi(v + 0.5)) : N'(-$rtoi(0.5 - v));
   endfunction

   logic signed [N-1:0] lut [1 << LA];
   for (genvar k = 0; k < (1 << LA); k++) begin : g_lut
      assign lut[k] = sin_entry(k);
   end

   logic [PW-1:0]          theta, rtheta, pending, inc_next;
   logic [DEC_LOG-1:0]     in_cnt, acc_cnt;
   logic                   v0, v1, v2, block_start;
   logic signed [N-1:0]    x0 [CH], x1 [CH], sin_r [CH], cos_r [CH];
   logic [LA-1:0]          addr0 [CH];
   logic signed [2*N-1:0]  p_i [CH], p_q [CH];
   logic signed [AW-1:0]   acc_i [CH], acc_q [CH], sum_i [CH], sum_q [CH];
   logic [N-1:0]           mon_sel;
   int                     sel_idx;

   assign block_start = sample_valid && (in_cnt == '0);
   assign inc_next    = phase_inc_load ? phase_inc : pending;

   // Increment changes only on block boundaries so every block is demodulated at one frequency.
   always_ff @(posedge CLK) begin
      if (reset) begin
         theta      <= '0;
         pending    <= '0;
         inc_active <= '0;
         in_cnt     <= '0;
         v0         <= 1'b0;
      end else begin
         if (phase_inc_load) pending <= phase_inc;
         v0 <= sample_valid;
         if (sample_valid) begin
            in_cnt <= in_cnt + 1'b1;
            if (block_start) begin
               inc_active <= inc_next;
               theta      <= theta + inc_next;
            end else begin
               theta <= theta + inc_active;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      for (int c = 0; c < CH; c++) begin
         x0[c]    <= sample_in[c*N +: N];
         addr0[c] <= LA'((theta + phase_ofs[c*PW +: PW]) >> (PW - LA));
         sin_r[c] <= lut[addr0[c]];
         cos_r[c] <= lut[addr0[c] + QTR];
         x1[c]    <= x0[c];
         p_i[c]   <= x1[c] * cos_r[c];
         p_q[c]   <= x1[c] * sin_r[c];
      end
   end

   always_comb begin
      for (int c = 0; c < CH; c++) begin
         sum_i[c] = acc_i[c] + AW'(p_i[c]);
         sum_q[c] = acc_q[c] + AW'(p_q[c]);
      end
   end

   // The closing product is folded into the result and the accumulator restarts from zero.
   always_ff @(posedge CLK) begin
      if (reset) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         acc_cnt   <= '0;
         out_valid <= 1'b0;
         i_out     <= '0;
         q_out     <= '0;
         for (int c = 0; c < CH; c++) begin
            acc_i[c] <= '0;
            acc_q[c] <= '0;
         end
      end else begin
         v1        <= v0;
         v2        <= v1;
         out_valid <= 1'b0;
         if (v2) begin
            acc_cnt <= acc_cnt + 1'b1;
            if (acc_cnt == LAST) begin
               out_valid <= 1'b1;
               for (int c = 0; c < CH; c++) begin
                  i_out[c*N +: N] <= N'(sum_i[c] >>> SH);
                  q_out[c*N +: N] <= N'(sum_q[c] >>> SH);
                  acc_i[c]        <= '0;
                  acc_q[c]        <= '0;
               end
            end else begin
               for (int c = 0; c < CH; c++) begin
                  acc_i[c] <= sum_i[c];
                  acc_q[c] <= sum_q[c];
               end
            end
         end
      end
   end

   always_comb begin
      sel_idx = (int'(sel_ch) < CH) ? int'(sel_ch) : 0;
      mon_sel = sel_q ? q_out[sel_idx*N +: N] : i_out[sel_idx*N +: N];
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         rtheta  <= '0;
         ref_out <= 1'b0;
         ovf     <= '0;
         mon_out <= MINV;
      end else begin
         rtheta  <= rtheta + ref_phase_inc;
         ref_out <= rtheta[PW-1];
         mon_out <= {~mon_sel[N-1], mon_sel[N-2:0]};
         for (int c = 0; c < CH; c++) begin
            ovf[c] <= (sample_valid && (otr_in[c] || sample_in[c*N +: N] == MINV))
                      || (ovf[c] && !clear_ovf);
         end
      end
   end
endmodule

// File: tb/tb_iq_lockin_multi.sv
// tb/tb_iq_lockin_multi.sv - directed self-checking bench for iq_lockin_multi
module tb_iq_lockin_multi;
   localparam int N  = 14;
   localparam int CH = 2;
   localparam int PW = 32;

   logic             CLK = 1'b0;
   logic             reset;
   logic [CH*N-1:0]  sample_in;
   logic             sample_valid;
   logic [CH-1:0]    otr_in;
   logic [PW-1:0]    phase_inc;
   logic             phase_inc_load;
   logic [CH*PW-1:0] phase_ofs;
   logic [PW-1:0]    ref_phase_inc;
   logic             ref_out;
   logic [CH*N-1:0]  i_out, q_out;
   logic             out_valid;
   logic [0:0]       sel_ch;
   logic             sel_q;
   logic [N-1:0]     mon_out;
   logic [PW-1:0]    inc_active;
   logic [CH-1:0]    ovf;
   logic             clear_ovf;

   int tests = 0;
   int fails = 0;

   iq_lockin_multi dut (
      .CLK(CLK), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .otr_in(otr_in), .phase_inc(phase_inc), .phase_inc_load(phase_inc_load),
      .phase_ofs(phase_ofs), .ref_phase_inc(ref_phase_inc), .ref_out(ref_out),
      .i_out(i_out), .q_out(q_out), .out_valid(out_valid), .sel_ch(sel_ch),
      .sel_q(sel_q), .mon_out(mon_out), .inc_active(inc_active), .ovf(ovf),
      .clear_ovf(clear_ovf)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic int geti(input int c);
      logic signed [N-1:0] t;
      t = i_out[c*N +: N];
      return int'(t);
   endfunction

   function automatic int getq(input int c);
      logic signed [N-1:0] t;
      t = q_out[c*N +: N];
      return int'(t);
   endfunction

   task automatic do_reset();
      sample_in = '0; sample_valid = 1'b0; otr_in = '0; phase_inc = '0;
      phase_inc_load = 1'b0; phase_ofs = '0; ref_phase_inc = '0;
      sel_ch = '0; sel_q = 1'b0; clear_ovf = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_valid(output int got);
      got = 0;
      for (int n = 1; n <= 60; n++) begin
         tick();
         if (out_valid) begin
            got = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sample_in = {14'd77, 14'h2000}; sample_valid = 1'b1; otr_in = 2'b11;
      phase_inc = 32'h1234; phase_inc_load = 1'b1; phase_ofs = '0;
      ref_phase_inc = 32'h8000_0000; sel_ch = 1'b1; sel_q = 1'b1; clear_ovf = 1'b0;
      tick();
      tick();
      tests++; if (i_out !== '0) begin fails++; $display("FAIL reset_i_out got %0h want 0", i_out); end
      tests++; if (q_out !== '0) begin fails++; $display("FAIL reset_q_out got %0h want 0", q_out); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      tests++; if (ref_out !== 1'b0) begin fails++; $display("FAIL reset_ref_out got %b want 0", ref_out); end
      tests++; if (inc_active !== '0) begin fails++; $display("FAIL reset_inc_active got %0h want 0", inc_active); end
      tests++; if (ovf !== 2'b00) begin fails++; $display("FAIL reset_ovf got %b want 00", ovf); end
      tests++; if (mon_out !== 14'h2000) begin fails++; $display("FAIL reset_mon_out got %0h want 2000", mon_out); end
   endtask

   task automatic test_dc_lock();
      int got;
      int gap;
      do_reset();
      phase_inc = '0; phase_inc_load = 1'b1;
      tick();
      phase_inc_load = 1'b0;
      sample_in = {14'd0, 14'd1000}; sample_valid = 1'b1;
      wait_valid(got);
      tests++; if (got !== 19) begin fails++; $display("FAIL dc_first_latency got %0d want 19", got); end
      tests++; if (geti(0) !== 999) begin fails++; $display("FAIL dc_i0 got %0d want 999", geti(0)); end
      tests++; if (getq(0) !== 0) begin fails++; $display("FAIL dc_q0 got %0d want 0", getq(0)); end
      tests++; if (geti(1) !== 0) begin fails++; $display("FAIL dc_i1 got %0d want 0", geti(1)); end
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL dc_pulse_width got %b want 0", out_valid); end
      gap = 0;
      for (int m = 2; m <= 40; m++) begin
         tick();
         if (out_valid) begin
            gap = m;
            break;
         end
      end
      tests++; if (gap !== 16) begin fails++; $display("FAIL dc_block_period got %0d want 16", gap); end
      tests++; if (geti(0) !== 999) begin fails++; $display("FAIL dc_i0_block2 got %0d want 999", geti(0)); end
      sample_valid = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      tests++; if (geti(0) !== 999) begin fails++; $display("FAIL dc_i0_hold got %0d want 999", geti(0)); end
   endtask

   task automatic test_rotating();
      int got;
      do_reset();
      phase_inc = 32'h1000_0000; phase_inc_load = 1'b1;
      tick();
      phase_inc_load = 1'b0;
      sample_in = {14'd0, 14'd1000}; sample_valid = 1'b1;
      wait_valid(got);
      sample_valid = 1'b0;
      tests++; if (got == 0 || geti(0) < -1 || geti(0) > 0) begin
         fails++; $display("FAIL rot_i0 got %0d (valid at %0d) want -1..0", geti(0), got); end
      tests++; if (got == 0 || getq(0) < -1 || getq(0) > 0) begin
         fails++; $display("FAIL rot_q0 got %0d (valid at %0d) want -1..0", getq(0), got); end
      tests++; if (inc_active !== 32'h1000_0000) begin
         fails++; $display("FAIL rot_inc_active got %0h want 10000000", inc_active); end
   endtask

   task automatic test_phase_offset();
      int got;
      do_reset();
      phase_ofs = {32'h4000_0000, 32'h0000_0000};
      sample_in = {14'd1000, 14'd0}; sample_valid = 1'b1;
      wait_valid(got);
      sample_valid = 1'b0;
      tests++; if (got == 0 || geti(1) < -1 || geti(1) > 0) begin
         fails++; $display("FAIL ofs_i1 got %0d (valid at %0d) want -1..0", geti(1), got); end
      tests++; if (getq(1) !== 999) begin fails++; $display("FAIL ofs_q1 got %0d want 999", getq(1)); end
      sel_ch = 1'b1; sel_q = 1'b1;
      tick();
      tests++; if (mon_out !== 14'd9191) begin fails++; $display("FAIL mon_ch1_q got %0d want 9191", mon_out); end
      sel_ch = 1'b0; sel_q = 1'b0;
      tick();
      tests++; if (mon_out !== 14'd8192) begin fails++; $display("FAIL mon_ch0_i got %0d want 8192", mon_out); end
   endtask

   task automatic test_inc_load();
      logic [7:0] pat;
      do_reset();
      sample_in = '0; sample_valid = 1'b1;
      for (int s = 0; s <= 16; s++) begin
         phase_inc_load = (s == 5) || (s == 7);
         phase_inc = (s == 5) ? 32'h1234_5678 : (s == 7) ? 32'h0ABC_DEF0 : 32'h0;
         tick();
         if (s == 5) begin
            tests++; if (inc_active !== '0) begin fails++; $display("FAIL load_s5 got %0h want 0", inc_active); end
         end
         if (s == 15) begin
            tests++; if (inc_active !== '0) begin fails++; $display("FAIL load_s15 got %0h want 0", inc_active); end
         end
         if (s == 16) begin
            tests++; if (inc_active !== 32'h0ABC_DEF0) begin
               fails++; $display("FAIL load_next_block got %0h want abcdef0", inc_active); end
         end
      end
      phase_inc_load = 1'b0;
      sample_valid = 1'b0;
      do_reset();
      ref_phase_inc = 32'h4000_0000;
      pat = 8'b1100_1100;
      for (int k = 0; k < 8; k++) begin
         tick();
         tests++; if (ref_out !== pat[k]) begin
            fails++; $display("FAIL ref_pattern_%0d got %b want %b", k, ref_out, pat[k]); end
      end
   endtask

   task automatic test_ovf();
      do_reset();
      otr_in = 2'b10; sample_valid = 1'b1;
      tick();
      otr_in = 2'b00; sample_valid = 1'b0;
      tests++; if (ovf !== 2'b10) begin fails++; $display("FAIL ovf_set got %b want 10", ovf); end
      tick(); tick(); tick();
      tests++; if (ovf !== 2'b10) begin fails++; $display("FAIL ovf_sticky got %b want 10", ovf); end
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      tests++; if (ovf !== 2'b00) begin fails++; $display("FAIL ovf_clear got %b want 00", ovf); end
      otr_in = 2'b01;
      tick();
      otr_in = 2'b00;
      tests++; if (ovf !== 2'b00) begin fails++; $display("FAIL ovf_no_valid got %b want 00", ovf); end
      otr_in = 2'b10; sample_valid = 1'b1; clear_ovf = 1'b1;
      tick();
      otr_in = 2'b00; sample_valid = 1'b0; clear_ovf = 1'b0;
      tests++; if (ovf !== 2'b10) begin fails++; $display("FAIL ovf_set_beats_clear got %b want 10", ovf); end
      sample_in = {14'd5, 14'h2000}; sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      tests++; if (ovf !== 2'b11) begin fails++; $display("FAIL ovf_min_sample got %b want 11", ovf); end
   endtask

   initial begin
      test_reset();
      test_dc_lock();
      test_rotating();
      test_phase_offset();
      test_inc_load();
      test_ovf();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
